// File: rtl/fc_ifmap_loader.sv
// Collects pooled lane results into a local buffer, then replays entries 0..n-1 as ifmap writes
// and pulses fc_start. Optional FCL_CHKSUM_EN adds chksum_o (sum of drained data for the pass).
module fc_ifmap_loader #(
   parameter int POOL_NUM   = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int DEPTH      = 128
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 arm_i,
   input  logic [ADDR_WIDTH-1:0]                in_node_num_i,
   input  logic [POOL_NUM-1:0]                  pool_valid_i,
   input  logic [POOL_NUM-1:0]                  pool_last_i,
   input  logic [POOL_NUM-1:0][DATA_WIDTH-1:0]  pool_data_i,
   input  logic [POOL_NUM-1:0][ADDR_WIDTH-1:0]  pool_addr_i,
   output logic                                 ifmap_wren_o,
   output logic [ADDR_WIDTH-1:0]                ifmap_wrptr_o,
   output logic [DATA_WIDTH-1:0]                ifmap_wdata_o,
   output logic                                 fc_start_o,
   output logic                                 busy_o,
`ifdef FCL_CHKSUM_EN
   output logic [15:0]                          chksum_o,
`endif
   output logic                                 err_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_START   = 2'd3;

   logic [1:0]            r_state;
   logic [POOL_NUM-1:0]   r_last;
   logic [CW-1:0]         r_n;
   logic [CW-1:0]         r_cnt;
   logic                  r_wren;
   logic [ADDR_WIDTH-1:0] r_wrptr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_fc_start;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_buf [DEPTH];

   logic                  w_collect;
   logic                  w_arm;
   logic                  w_err_evt;
   logic                  w_drain_issue;
   logic [POOL_NUM-1:0]   w_in_range;
   logic [POOL_NUM-1:0]   w_last_next;
   logic [CW-1:0]         w_n_sel;
   logic [ADDR_WIDTH-1:0] w_rd_idx;

   always_comb begin
      w_collect     = (r_state == S_COLLECT);
      w_arm         = arm_i && (r_state == S_IDLE);
      w_last_next   = r_last | (pool_valid_i & pool_last_i);
      w_drain_issue = (r_state == S_DRAIN) && (r_cnt != r_n);
      w_rd_idx      = ADDR_WIDTH'(r_cnt);
      w_in_range    = '0;
      w_err_evt     = 1'b0;
      for (int l = 0; l < POOL_NUM; l++) begin
         w_in_range[l] = (32'(pool_addr_i[l]) < DEPTH);
         if (pool_valid_i[l] && (!w_collect || !w_in_range[l]))
            w_err_evt = 1'b1;
      end
      // zero (or anything past the buffer) means a full-buffer drain
      if ((in_node_num_i == '0) || (32'(in_node_num_i) > DEPTH))
         w_n_sel = DEPTH_N;
      else
         w_n_sel = CW'(in_node_num_i);
   end

   // Unreset storage: later lanes overwrite earlier ones on an address collision.
   always_ff @(posedge clk) begin
      if (w_collect) begin
         for (int l = 0; l < POOL_NUM; l++) begin
            if (pool_valid_i[l] && w_in_range[l])
               r_buf[pool_addr_i[l]] <= pool_data_i[l];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_last     <= '0;
         r_n        <= '0;
         r_cnt      <= '0;
         r_wren     <= 1'b0;
         r_wrptr    <= '0;
         r_wdata    <= '0;
         r_fc_start <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= (w_arm ? 1'b0 : r_err) | w_err_evt;
         case (r_state)
            S_IDLE: begin
               if (arm_i) begin
                  r_state <= S_COLLECT;
                  r_last  <= '0;
                  r_n     <= w_n_sel;
                  r_cnt   <= '0;
               end
            end
            S_COLLECT: begin
               r_last <= w_last_next;
               if (&r_last)
                  r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_drain_issue) begin
                  r_wren  <= 1'b1;
                  r_wrptr <= w_rd_idx;
                  r_wdata <= r_buf[w_rd_idx];
                  r_cnt   <= r_cnt + 1'b1;
               end else begin
                  r_wren     <= 1'b0;
                  r_wrptr    <= '0;
                  r_wdata    <= '0;
                  r_fc_start <= 1'b1;
                  r_state    <= S_START;
               end
            end
            default: begin
               r_fc_start <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

`ifdef FCL_CHKSUM_EN
   logic [15:0] r_chksum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_chksum <= '0;
      else if (w_arm)
         r_chksum <= '0;
      else if (w_drain_issue)
         r_chksum <= r_chksum + 16'(r_buf[w_rd_idx]);
   end

   assign chksum_o = r_chksum;
`endif

   assign ifmap_wren_o  = r_wren;
   assign ifmap_wrptr_o = r_wrptr;
   assign ifmap_wdata_o = r_wdata;
   assign fc_start_o    = r_fc_start;
   assign busy_o        = (r_state != S_IDLE);
   assign err_o         = r_err;

endmodule

// File: tb/tb_fc_ifmap_loader.sv
// Randomised scoreboard bench for fc_ifmap_loader: a buffer model predicts every drain write,
// its cycle and the fc_start pulse; a negedge monitor compares whatever the DUT emits.
`timescale 1ns/1ps
module tb_fc_ifmap_loader;

   localparam int PN    = 4;
   localparam int DW    = 8;
   localparam int AW    = 7;
   localparam int DEPTH = 100;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic                 arm_i = 1'b0;
   logic [AW-1:0]        in_node_num_i = '0;
   logic [PN-1:0]        pool_valid_i = '0;
   logic [PN-1:0]        pool_last_i = '0;
   logic [PN-1:0][DW-1:0] pool_data_i = '0;
   logic [PN-1:0][AW-1:0] pool_addr_i = '0;
   logic                 ifmap_wren_o;
   logic [AW-1:0]        ifmap_wrptr_o;
   logic [DW-1:0]        ifmap_wdata_o;
   logic                 fc_start_o;
   logic                 busy_o;
   logic                 err_o;
`ifdef FCL_CHKSUM_EN
   logic [15:0]          chksum_o;
`endif

   always #5 clk = ~clk;

   fc_ifmap_loader #(.POOL_NUM(PN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .in_node_num_i(in_node_num_i),
      .pool_valid_i(pool_valid_i), .pool_last_i(pool_last_i),
      .pool_data_i(pool_data_i), .pool_addr_i(pool_addr_i),
      .ifmap_wren_o(ifmap_wren_o), .ifmap_wrptr_o(ifmap_wrptr_o),
      .ifmap_wdata_o(ifmap_wdata_o), .fc_start_o(fc_start_o), .busy_o(busy_o),
`ifdef FCL_CHKSUM_EN
      .chksum_o(chksum_o),
`endif
      .err_o(err_o));

   typedef struct {
      bit is_start;
      int ptr;
      int data;
      int cyc;
      int sum;
   } exp_t;

   exp_t      q[$];
   int        checks = 0;
   int        errs = 0;
   int        cyc = 0;
   logic [7:0] model_buf [DEPTH];
   bit [PN-1:0] m_last;
   bit        m_collect = 1'b0;
   int        m_n = 0;
   bit        exp_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every wren/fc_start must match the next expected event at its predicted cycle.
   exp_t mon_e;
   bit   mon_ok;
   bit   busy_next_chk = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_next_chk = 1'b0;
      end else begin
         if (busy_next_chk) begin
            checks++;
            if (busy_o !== 1'b0) begin
               errs++;
               $display("FAIL busy_after_start actual=%0b required=0", busy_o);
            end
         end
         busy_next_chk = fc_start_o;
         if (ifmap_wren_o || fc_start_o) begin
            checks++;
            if (q.size() == 0) begin
               errs++;
               $display("FAIL unexpected_output wren=%0b ptr=%0d start=%0b required=none cycle=%0d",
                        ifmap_wren_o, ifmap_wrptr_o, fc_start_o, cyc);
            end else begin
               mon_e = q.pop_front();
               if (mon_e.is_start) begin
                  mon_ok = fc_start_o && !ifmap_wren_o && busy_o && (mon_e.cyc == cyc);
`ifdef FCL_CHKSUM_EN
                  mon_ok = mon_ok && (chksum_o == mon_e.sum[15:0]);
`endif
               end else begin
                  mon_ok = ifmap_wren_o && !fc_start_o && (ifmap_wrptr_o == mon_e.ptr) &&
                           (ifmap_wdata_o == mon_e.data) && (mon_e.cyc == cyc);
               end
               if (!mon_ok) begin
                  errs++;
                  $display("FAIL drain_event actual: wren=%0b start=%0b ptr=%0d data=%0h cyc=%0d required: start=%0b ptr=%0d data=%0h cyc=%0d sum=%0h",
                           ifmap_wren_o, fc_start_o, ifmap_wrptr_o, ifmap_wdata_o, cyc,
                           mon_e.is_start, mon_e.ptr, mon_e.data, mon_e.cyc, mon_e.sum);
               end
            end
         end
      end
   end

   task automatic arm(input int n);
      @(posedge clk); #1;
      arm_i = 1'b1;
      in_node_num_i = AW'(n);
      pool_valid_i = '0;
      pool_last_i = '0;
      @(posedge clk); #1;
      arm_i = 1'b0;
      m_collect = 1'b1;
      m_last = '0;
      m_n = (n == 0) ? DEPTH : n;
      exp_err = 1'b0;
      chk("arm_err_clear", err_o, 0);
      chk("arm_busy", busy_o, 1);
`ifdef FCL_CHKSUM_EN
      chk("arm_chksum_clear", chksum_o, 0);
`endif
   endtask

   // One input cycle; the model applies the pass rules to it.
   task automatic beat(input logic [PN-1:0] v, input logic [PN-1:0] la,
                       input logic [PN-1:0][DW-1:0] d, input logic [PN-1:0][AW-1:0] a);
      int s;
      @(posedge clk); #1;
      arm_i = 1'b0;
      pool_valid_i = v;
      pool_last_i = la;
      pool_data_i = d;
      pool_addr_i = a;
      for (int l = 0; l < PN; l++) begin
         if (v[l]) begin
            if (!m_collect || a[l] >= DEPTH) exp_err = 1'b1;
            else model_buf[a[l]] = d[l];
            if (m_collect && la[l]) m_last[l] = 1'b1;
         end
      end
      if (m_collect && (&m_last)) begin
         m_collect = 1'b0;
         s = 0;
         for (int i = 0; i < m_n; i++) begin
            q.push_back('{1'b0, i, int'(model_buf[i]), cyc + 3 + i, 0});
            s += int'(model_buf[i]);
         end
         q.push_back('{1'b1, 0, 0, cyc + 3 + m_n, s % 65536});
      end
   endtask

   task automatic quiet();
      @(posedge clk); #1;
      arm_i = 1'b0;
      pool_valid_i = '0;
      pool_last_i = '0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (!busy_o && q.size() == 0) done = 1'b1;
      end
      chk({name, "_completed"}, done, 1);
      chk({name, "_err"}, err_o, exp_err);
   endtask

   task automatic rand_beats(input bit bad_addr);
      logic [PN-1:0][DW-1:0] d;
      logic [PN-1:0][AW-1:0] a;
      logic [PN-1:0] v, la;
      int nb;
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
         d = $urandom;
         v = PN'($urandom);
         for (int l = 0; l < PN; l++)
            a[l] = AW'($urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1));
         if (bad_addr && b == 0) begin
            v[2] = 1'b1;
            a[2] = 7'd127;
         end
         beat(v, '0, d, a);
      end
      for (int k = 0; m_collect && k < 50; k++) begin
         d = $urandom;
         for (int l = 0; l < PN; l++) a[l] = AW'($urandom_range(0, DEPTH - 1));
         la = (k >= 4) ? '1 : PN'($urandom);
         v = PN'($urandom) | la;
         beat(v, la, d, a);
      end
   endtask

   task automatic random_pass(input int n_in, input bit bad_addr, input bit noise);
      logic [PN-1:0][AW-1:0] a;
      if (noise && n_in > 0 && n_in < 8) n_in = 8;
      arm(n_in);
      rand_beats(bad_addr);
      quiet();
      if (noise) begin
         @(posedge clk); #1;
         arm_i = 1'b1;
         in_node_num_i = 7'd3;
         @(posedge clk); #1;
         arm_i = 1'b0;
         for (int l = 0; l < PN; l++) a[l] = AW'($urandom_range(0, DEPTH - 1));
         beat(4'b0010, '0, $urandom, a);
         quiet();
      end
      wait_idle("random_pass");
   endtask

   logic [PN-1:0][DW-1:0] fd;
   logic [PN-1:0][AW-1:0] fa;
   bit found;

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("reset_wren", ifmap_wren_o, 0);
      chk("reset_wrptr", ifmap_wrptr_o, 0);
      chk("reset_wdata", ifmap_wdata_o, 0);
      chk("reset_start", fc_start_o, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_err", err_o, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Fill every entry so later drains of unwritten entries have known content; n=0 -> DEPTH.
      arm(0);
      for (int b = 0; b < DEPTH / PN; b++) begin
         fd = $urandom;
         for (int l = 0; l < PN; l++) fa[l] = AW'(PN * b + l);
         beat('1, (b == DEPTH / PN - 1) ? '1 : '0, fd, fa);
      end
      quiet();
      wait_idle("fill_n0");

      // Addresses 0..7 carry 0x10+addr, each lane signals last once.
      arm(8);
      beat('1, '0, {8'h13, 8'h12, 8'h11, 8'h10}, {7'd3, 7'd2, 7'd1, 7'd0});
      beat('1, '1, {8'h17, 8'h16, 8'h15, 8'h14}, {7'd7, 7'd6, 7'd5, 7'd4});
      quiet();
      wait_idle("basic_n8");

      // Lane collision on address 5: lane 3 wins.
      arm(8);
      beat(4'b1001, '0, {8'hBB, 8'h00, 8'h00, 8'hAA}, {7'd5, 7'd0, 7'd0, 7'd5});
      beat('1, '1, $urandom, {7'd43, 7'd42, 7'd41, 7'd40});
      quiet();
      wait_idle("collision");

      // Out-of-range address with full drain.
      random_pass(0, 1'b1, 1'b0);

      // Valid in IDLE flags err and leaves buffer alone; arm/valid during DRAIN do not disturb.
      beat(4'b0010, '0, {8'h00, 8'h00, 8'h5A, 8'h00}, {7'd0, 7'd0, 7'd3, 7'd0});
      quiet();
      @(negedge clk);
      chk("idle_valid_err", err_o, 1);
      random_pass(12, 1'b0, 1'b1);
      random_pass(0, 1'b0, 1'b1);

      // All-FF data for the checksum option.
      arm(8);
      beat('1, '0, {4{8'hFF}}, {7'd3, 7'd2, 7'd1, 7'd0});
      beat('1, '1, {4{8'hFF}}, {7'd7, 7'd6, 7'd5, 7'd4});
      quiet();
      wait_idle("all_ff");

      // Reset in the middle of a drain aborts silently; the next pass is normal.
      arm(10);
      rand_beats(1'b0);
      quiet();
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (ifmap_wren_o && ifmap_wrptr_o == 7'd3) found = 1'b1;
      end
      chk("abort_reached_ptr3", found, 1);
      #2 rst_n = 1'b0;
      q.delete();
      m_collect = 1'b0;
      exp_err = 1'b0;
      #1;
      chk("abort_wren", ifmap_wren_o, 0);
      chk("abort_start", fc_start_o, 0);
      chk("abort_busy", busy_o, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_stays_idle", busy_o, 0);
      random_pass(10, 1'b0, 1'b0);

      random_pass(1, 1'b0, 1'b0);
      random_pass(DEPTH, 1'b0, 1'b0);
      for (int p = 0; p < 6; p++)
         random_pass($urandom_range(0, 1) ? 0 : $urandom_range(1, DEPTH),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
